// File: rtl/y86_alu_pkg.sv
// Shared types and constants for the Y86-64 ALU multi-cycle multiplier.
package y86_alu_pkg;

  // Default operand width; the product is twice this.
  localparam int unsigned MUL_W_DEFAULT = 64;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Booth radix-2 operation selected by {Q[0], Q_1}.
  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // Raw Booth pair encodings.
  localparam logic [1:0] BOOTH_PAIR_ADD = 2'b01;
  localparam logic [1:0] BOOTH_PAIR_SUB = 2'b10;

  // Decode a Booth bit pair into the operation it requests.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    logic [1:0] pair;
    pair = {q0, q_1};
    if (pair == BOOTH_PAIR_ADD) begin
      booth_decode = BOOTH_ADD;
    end else if (pair == BOOTH_PAIR_SUB) begin
      booth_decode = BOOTH_SUB;
    end else begin
      booth_decode = BOOTH_NOP;
    end
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// N-bit gate-level ripple adder with carry-in; the caller supplies M or ~M.
module booth_addsub #(
  parameter int unsigned N = 65
) (
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o
);

  // carry[i] is the carry into bit i; the carry out of the top bit is not needed.
  logic [N-1:0] carry;

  assign carry[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    logic p;
    assign p        = x_i[i] ^ y_i[i];
    assign sum_o[i] = p ^ carry[i];
    if (i < N - 1) begin : g_carry
      assign carry[i+1] = (x_i[i] & y_i[i]) | (carry[i] & p);
    end
  end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth signed multiplier controller: W iterations over a W+1-bit adder.
module booth_mul_ctrl
  import y86_alu_pkg::*;
#(
  parameter int unsigned W = MUL_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] prod_lo,
  output logic [W-1:0] prod_hi,
  output logic         ovf
);

  localparam int unsigned AW    = W + 1;
  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

  mul_state_t       state_q, state_d;
  logic [AW-1:0]    m_q, m_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [W-1:0]     mq_q, mq_d;
  logic             q1_q, q1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  booth_op_t        op;
  logic [AW-1:0]    add_y;
  logic             add_cin;
  logic [AW-1:0]    add_sum;
  logic [AW-1:0]    step_sum;
  logic [W:0]       top_bits;

  // Select the adder operand (M or ~M) and carry-in from the current Booth pair.
  always_comb begin
    op      = booth_decode(mq_q[0], q1_q);
    add_y   = m_q;
    add_cin = 1'b0;
    if (op == BOOTH_SUB) begin
      add_y   = ~m_q;
      add_cin = 1'b1;
    end
  end

  booth_addsub #(
    .N (AW)
  ) u_addsub (
    .x_i   (acc_q),
    .y_i   (add_y),
    .cin_i (add_cin),
    .sum_o (add_sum)
  );

  // A no-op step keeps the accumulator; add/sub steps take the adder result.
  assign step_sum = (op == BOOTH_NOP) ? acc_q : add_sum;

  // State and datapath registers; reset clears everything and wins over handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: load on start handshake, one Booth step per RUN cycle.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          m_d     = {a[W-1], a};
          acc_d   = '0;
          mq_d    = b;
          q1_d    = 1'b0;
          cnt_d   = CNT_W'(W - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        // Arithmetic shift right of {sum, Q, Q_1}; the sign bit of sum replicates.
        acc_d = {step_sum[AW-1], step_sum[AW-1:1]};
        mq_d  = {step_sum[0], mq_q[W-1:1]};
        q1_d  = mq_q[0];
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake flags are pure state decodes.
  assign start_ready = (state_q == IDLE);
  assign res_valid   = (state_q == DONE);

  // Product straight from the shift registers; stable while parked in DONE.
  assign prod_hi = acc_q[W-1:0];
  assign prod_lo = mq_q;

  // Overflow when product bits [2W-1:W-1] are not all copies of the sign.
  assign top_bits = {acc_q[W-1:0], mq_q[W-1]};
  assign ovf      = ~((&top_bits) | ~(|top_bits));

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl (W=64): vector table plus corner sequences.
module tb_booth_mul_ctrl;

  localparam int unsigned W = 64;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] prod_lo;
  logic [W-1:0] prod_hi;
  logic         ovf;

  int checks;
  int errors;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         ovf;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs [NVEC];

  booth_mul_ctrl #(
    .W (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .prod_lo     (prod_lo),
    .prod_hi     (prod_hi),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands at a falling edge and complete the handshake on the next rising edge.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a           = av;
    b           = bv;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a           = {$urandom, $urandom};
    b           = {$urandom, $urandom};
  endtask

  // Count falling edges from the handshake until res_valid; -1 on timeout.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 200);
    if (!res_valid) lat = -1;
  endtask

  // Accept the result and confirm the block is back in IDLE one cycle later.
  task automatic release_res(input string name);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({name, "_idle_ready"}, W'(start_ready), W'(1'b1));
    chk({name, "_idle_valid"}, W'(res_valid), W'(1'b0));
  endtask

  initial begin
    int           lat;
    int           stray;
    logic [W-1:0] held_lo;
    logic [W-1:0] held_hi;

    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    start_valid = 1'b0;
    res_ready   = 1'b0;
    a           = '0;
    b           = '0;

    vecs[0] = '{64'd3, 64'd5, 64'd15, 64'd0, 1'b0};
    vecs[1] = '{-64'sd7, 64'd6, 64'hFFFF_FFFF_FFFF_FFD6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[2] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 64'h4000_0000_0000_0000, 1'b1};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 1'b1};
    vecs[4] = '{64'd0, -64'sd5, 64'd0, 64'd0, 1'b0};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0};
    vecs[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b1};
    vecs[7] = '{64'h0000_0001_0000_0000, 64'h0000_0000_8000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1};
    vecs[8] = '{64'hFFFF_FFFF_0000_0000, 64'h0000_0000_8000_0000, 64'h8000_0000_0000_0000,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_start_ready", W'(start_ready), W'(1'b1));
    chk("rst_res_valid", W'(res_valid), W'(1'b0));
    chk("rst_prod_lo", prod_lo, '0);
    chk("rst_prod_hi", prod_hi, '0);
    chk("rst_ovf", W'(ovf), W'(1'b0));

    // Table-driven products, each with its latency check.
    for (int i = 0; i < NVEC; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_result(lat);
      chk($sformatf("v%0d_latency", i), W'(lat), W'(65));
      chk($sformatf("v%0d_prod_lo", i), prod_lo, vecs[i].lo);
      chk($sformatf("v%0d_prod_hi", i), prod_hi, vecs[i].hi);
      chk($sformatf("v%0d_ovf", i), W'(ovf), W'(vecs[i].ovf));
      release_res($sformatf("v%0d", i));
    end

    // Backpressure: park in DONE for 10 cycles with a stray start pulse.
    start_op(64'h123, 64'h456);
    wait_result(lat);
    chk("bp_latency", W'(lat), W'(65));
    held_lo = prod_lo;
    held_hi = prod_hi;
    chk("bp_prod_lo", prod_lo, 64'h4_EDC2);
    chk("bp_prod_hi", prod_hi, 64'd0);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        a           = 64'd9;
        b           = 64'd9;
        start_valid = 1'b1;
      end else begin
        start_valid = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("bp%0d_valid", c), W'(res_valid), W'(1'b1));
      chk($sformatf("bp%0d_ready", c), W'(start_ready), W'(1'b0));
      chk($sformatf("bp%0d_lo", c), prod_lo, held_lo);
      chk($sformatf("bp%0d_hi", c), prod_hi, held_hi);
    end
    start_valid = 1'b0;
    release_res("bp");
    chk("bp_after_lo", prod_lo, 64'h4_EDC2);

    // Reset at RUN step 20 discards the operation.
    start_op(64'h55, 64'h77);
    repeat (20) @(negedge clk);
    chk("abort_running", W'(start_ready), W'(1'b0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", W'(start_ready), W'(1'b1));
    chk("abort_valid", W'(res_valid), W'(1'b0));
    chk("abort_lo", prod_lo, '0);
    chk("abort_hi", prod_hi, '0);
    chk("abort_ovf", W'(ovf), W'(1'b0));
    stray = 0;
    repeat (80) begin
      @(negedge clk);
      if (res_valid) stray++;
    end
    chk("abort_no_result", W'(stray), W'(0));

    start_op(64'd12, -64'sd12);
    wait_result(lat);
    chk("post_latency", W'(lat), W'(65));
    chk("post_prod_lo", prod_lo, 64'hFFFF_FFFF_FFFF_FF70);
    chk("post_prod_hi", prod_hi, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("post_ovf", W'(ovf), W'(1'b0));
    release_res("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
